gshare_predictor: RTL

Parametrised successor to the fixed GHR/branching-buffer predictor. It combines a global-history register and a pattern history table (PHT) of 2-bit saturating counters, indexed gshare-style (PC XOR history), with a tagged, direct-mapped branch target buffer (BTB). It sits beside the F-stage PC mux, giving a same-cycle taken/target prediction for `pc_f_i`. It trains from resolved branches in E.

---
 rtl/gshare_predictor_pkg.sv | 42 ++++
 rtl/gshare_predictor_if.sv | 35 +++
 rtl/branch_target_table.sv | 43 ++++
 rtl/gshare_predictor.sv | 116 +++++++++++
 4 files changed

// File: rtl/gshare_predictor_pkg.sv
// ============================================================================
// Module      : branch_pred_pkg
// Description : Shared types and helpers for the gshare branch predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_pred_pkg;

    // Tags are stored zero-extended so one struct serves every PC_BITS choice
    localparam int BTB_TAG_MAX = 32;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_COND = 2'b01,
        BR_JUMP = 2'b10
    } branch_op_t;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } sat_cnt_t;

    typedef struct packed {
        logic                   valid;
        logic [BTB_TAG_MAX-1:0] tag;
        logic                   is_jump;
        logic [31:0]            target;
    } btb_entry_t;

    function automatic sat_cnt_t sat_update(input sat_cnt_t cnt, input logic taken);
        if (taken) begin
            return (cnt == ST) ? ST : sat_cnt_t'(cnt + 2'd1);
        end
        return (cnt == SNT) ? SNT : sat_cnt_t'(cnt - 2'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/gshare_predictor_if.sv
// ============================================================================
// Module      : gshare_predictor_if
// Description : F-lookup and E-training signal bundle of the gshare predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gshare_predictor_if #(
    parameter int PC_BITS = 10
);
    logic               stall_e_i;
    logic [PC_BITS-1:0] pc_f_i;
    logic [PC_BITS-1:0] pc_e_i;
    logic [31:0]        pc_target_e_i;
    logic               pc_src_res_e_i;
    logic               target_match_e_i;
    logic [1:0]         branch_op_e_i;
    logic               pc_src_pred_f_o;
    logic [31:0]        pred_pc_target_f_o;
    logic               btb_hit_f_o;

    modport master (
        output stall_e_i, pc_f_i, pc_e_i, pc_target_e_i,
               pc_src_res_e_i, target_match_e_i, branch_op_e_i,
        input  pc_src_pred_f_o, pred_pc_target_f_o, btb_hit_f_o
    );

    modport slave (
        input  stall_e_i, pc_f_i, pc_e_i, pc_target_e_i,
               pc_src_res_e_i, target_match_e_i, branch_op_e_i,
        output pc_src_pred_f_o, pred_pc_target_f_o, btb_hit_f_o
    );
endinterface

`default_nettype wire

// File: rtl/branch_target_table.sv
// ============================================================================
// Module      : branch_target_table
// Description : Direct-mapped BTB array, two async read ports, one write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_target_table
    import branch_pred_pkg::*;
#(
    parameter int IDX_BITS = 4
) (
    input  wire logic                clk_i,
    input  wire logic                reset_i,
    input  wire logic [IDX_BITS-1:0] f_idx_i,
    output btb_entry_t               f_entry_o,
    input  wire logic [IDX_BITS-1:0] e_idx_i,
    output btb_entry_t               e_entry_o,
    input  wire logic                we_i,
    input  wire logic [IDX_BITS-1:0] w_idx_i,
    input  btb_entry_t               w_entry_i
);
    localparam int ENTRIES = 2 ** IDX_BITS;

    btb_entry_t entries_q [ENTRIES];

    // Only valid bits are reset; tag and target are don't-care while invalid
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries_q[i].valid <= 1'b0;
            end
        end else if (we_i) begin
            entries_q[w_idx_i] <= w_entry_i;
        end
    end

    assign f_entry_o = entries_q[f_idx_i];
    assign e_entry_o = entries_q[e_idx_i];

endmodule

`default_nettype wire

// File: rtl/gshare_predictor.sv
// ============================================================================
// Module      : gshare_predictor
// Description : Gshare PHT + tagged BTB; same-cycle F prediction, E training.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gshare_predictor
    import branch_pred_pkg::*;
#(
    parameter int PC_BITS      = 10,
    parameter int GHR_BITS     = 4,
    parameter int PHT_IDX_BITS = 6,
    parameter int BTB_IDX_BITS = 4
) (
    input wire logic           clk_i,
    input wire logic           reset_i,
    gshare_predictor_if.slave  bus
);
    localparam int PHT_SIZE = 2 ** PHT_IDX_BITS;

    if ((GHR_BITS > PHT_IDX_BITS) || (BTB_IDX_BITS + 2 >= PC_BITS)) begin : g_param_check
        $error("gshare_predictor: illegal GHR_BITS/PHT_IDX_BITS/BTB_IDX_BITS/PC_BITS");
    end

    logic [GHR_BITS-1:0]     ghr_q, ghr_d;
    sat_cnt_t                pht_q [PHT_SIZE];
    sat_cnt_t                pht_cnt_d;
    logic                    pht_we_d;
    logic                    btb_we_d;
    btb_entry_t              btb_entry_d;

    logic [PHT_IDX_BITS-1:0] w_pht_f_idx, w_pht_e_idx;
    logic [BTB_IDX_BITS-1:0] w_btb_f_idx, w_btb_e_idx;
    logic [BTB_TAG_MAX-1:0]  w_f_tag, w_e_tag;
    btb_entry_t              w_f_entry, w_e_entry;
    logic                    w_f_hit, w_e_hit;
    logic                    w_is_cond, w_is_jump, w_train;
    sat_cnt_t                w_pht_f_cnt;
    logic                    w_unused;

    assign w_pht_f_idx = bus.pc_f_i[PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(ghr_q);
    assign w_pht_e_idx = bus.pc_e_i[PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(ghr_q);
    assign w_btb_f_idx = bus.pc_f_i[BTB_IDX_BITS+1:2];
    assign w_btb_e_idx = bus.pc_e_i[BTB_IDX_BITS+1:2];
    assign w_f_tag     = BTB_TAG_MAX'(bus.pc_f_i[PC_BITS-1:BTB_IDX_BITS+2]);
    assign w_e_tag     = BTB_TAG_MAX'(bus.pc_e_i[PC_BITS-1:BTB_IDX_BITS+2]);
    assign w_unused    = ^{bus.pc_f_i[1:0], bus.pc_e_i[1:0]};

    branch_target_table #(
        .IDX_BITS (BTB_IDX_BITS)
    ) u_btb (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .f_idx_i   (w_btb_f_idx),
        .f_entry_o (w_f_entry),
        .e_idx_i   (w_btb_e_idx),
        .e_entry_o (w_e_entry),
        .we_i      (btb_we_d),
        .w_idx_i   (w_btb_e_idx),
        .w_entry_i (btb_entry_d)
    );

    assign w_f_hit     = w_f_entry.valid && (w_f_entry.tag == w_f_tag);
    assign w_e_hit     = w_e_entry.valid && (w_e_entry.tag == w_e_tag);
    assign w_pht_f_cnt = pht_q[w_pht_f_idx];

    assign bus.btb_hit_f_o        = w_f_hit;
    assign bus.pc_src_pred_f_o    = w_f_hit && (w_f_entry.is_jump || w_pht_f_cnt[1]);
    assign bus.pred_pc_target_f_o = w_f_hit ? w_f_entry.target : 32'd0;

    always_comb begin
        w_is_cond   = (bus.branch_op_e_i == BR_COND);
        w_is_jump   = (bus.branch_op_e_i == BR_JUMP);
        w_train     = !bus.stall_e_i && (w_is_cond || w_is_jump);
        ghr_d       = ghr_q;
        pht_we_d    = 1'b0;
        pht_cnt_d   = pht_q[w_pht_e_idx];
        btb_we_d    = 1'b0;
        btb_entry_d = w_e_entry;

        if (w_train) begin
            ghr_d = (ghr_q << 1) | GHR_BITS'(w_is_jump || bus.pc_src_res_e_i);
            if (w_is_cond) begin
                pht_we_d  = 1'b1;
                pht_cnt_d = sat_update(pht_q[w_pht_e_idx], bus.pc_src_res_e_i);
            end
            if (bus.pc_src_res_e_i && (!w_e_hit || !bus.target_match_e_i)) begin
                btb_we_d    = 1'b1;
                btb_entry_d = '{valid: 1'b1, tag: w_e_tag, is_jump: w_is_jump,
                                target: bus.pc_target_e_i};
            end else if (w_is_cond && !bus.pc_src_res_e_i && w_e_hit && w_e_entry.is_jump) begin
                // A jump slot reused by a not-taken conditional is stale
                btb_we_d          = 1'b1;
                btb_entry_d.valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ghr_q <= '0;
            for (int i = 0; i < PHT_SIZE; i++) begin
                pht_q[i] <= WNT;
            end
        end else begin
            ghr_q <= ghr_d;
            if (pht_we_d) begin
                pht_q[w_pht_e_idx] <= pht_cnt_d;
            end
        end
    end

endmodule

`default_nettype wire
